// File: rtl/corr_readout_sched_if.sv
// Result stream from the readout scheduler: show-ahead valid/ready handshake
// carrying the correlator id, its count and the {High, Low} correlation pair.
interface corr_readout_sched_if;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_id;
  logic [31:0] res_cnt;
  logic [63:0] res_corr;

  modport master (output res_valid, output res_id, output res_cnt, output res_corr,
                  input  res_ready);
  modport slave  (input  res_valid, input  res_id, input  res_cnt, input  res_corr,
                  output res_ready);
endinterface

// File: rtl/corr_readout_sched.sv
// Round-robin readout engine for the 32-correlator array: steals idle register
// bus cycles from the host, reads Cnt/Low/High/Status and queues one result each.
module corr_readout_sched #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] CORR_BASE   = 32'hFE00_0600,
  parameter logic [31:0] CORR_STRIDE = 32'h0000_0010,
  parameter logic [31:0] CTRL_ADDR   = 32'hFE00_0110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] h_addr,
  input  logic [31:0] h_Wdata,
  input  logic        h_write,
  input  logic        h_read,
  output logic [31:0] h_Rdata,
  output logic [31:0] addr,
  output logic [31:0] Wdata,
  output logic        write,
  output logic        read,
  input  logic [31:0] Rdata,
  input  logic [31:0] seen,
  corr_readout_sched_if.master res
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_CNT  = 3'd1;
  localparam logic [2:0] S_RD_LOW  = 3'd2;
  localparam logic [2:0] S_RD_HIGH = 3'd3;
  localparam logic [2:0] S_RD_STAT = 3'd4;
  localparam logic [2:0] S_PUSH    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [4:0]    rr_ptr_q, rr_ptr_d;
  logic [31:0]   mask_q, mask_d;
  logic          enable_q, enable_d;
  logic [15:0]   done_q, done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [4:0]    sel_id_q, sel_id_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   low_q, low_d;
  logic [31:0]   high_q, high_d;
  logic [100:0]  mem_q [FIFO_DEPTH];

  logic          host_own, ctrl_hit, eng_rd, advance;
  logic [31:0]   rd_off, rd_addr, ctrl_val, pending;
  logic          found;
  logic [4:0]    pick_id, idx;
  logic          push, pop;
  logic [100:0]  head;

  assign host_own = h_read | h_write;
  assign ctrl_hit = host_own && (h_addr == CTRL_ADDR);
  assign eng_rd   = (state_q == S_RD_CNT) || (state_q == S_RD_LOW) ||
                    (state_q == S_RD_HIGH) || (state_q == S_RD_STAT);
  assign advance  = eng_rd && !host_own;
  assign ctrl_val = {done_q, 8'(count_q), 7'd0, enable_q};
  assign pending  = seen & ~mask_q;
  assign push     = (state_q == S_PUSH);
  assign pop      = res.res_valid && res.res_ready;

  always_comb begin
    rd_off = 32'h0;
    case (state_q)
      S_RD_LOW:  rd_off = 32'h4;
      S_RD_HIGH: rd_off = 32'h8;
      S_RD_STAT: rd_off = 32'hC;
      default:   rd_off = 32'h0;
    endcase
    rd_addr = CORR_BASE + CORR_STRIDE * {27'd0, sel_id_q} + rd_off;
  end

  // First pending correlator at or after rr_ptr, wrapping through 31 -> 0.
  always_comb begin
    found   = 1'b0;
    pick_id = 5'd0;
    idx     = 5'd0;
    for (int i = 0; i < 32; i++) begin
      idx = rr_ptr_q + 5'(i);
      if (!found && pending[idx]) begin
        found   = 1'b1;
        pick_id = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    mask_d   = 32'h0;
    done_d   = done_q;
    sel_id_d = sel_id_q;
    cnt_d    = cnt_q;
    low_d    = low_q;
    high_d   = high_q;
    enable_d = enable_q;
    if (h_write && ctrl_hit) enable_d = h_Wdata[0];
    case (state_q)
      S_IDLE: begin
        if (enable_q && found && (count_q < DEPTH_C)) begin
          sel_id_d = pick_id;
          state_d  = S_RD_CNT;
        end
      end
      S_RD_CNT:  if (advance) begin cnt_d  = Rdata; state_d = S_RD_LOW;  end
      S_RD_LOW:  if (advance) begin low_d  = Rdata; state_d = S_RD_HIGH; end
      S_RD_HIGH: if (advance) begin high_d = Rdata; state_d = S_RD_STAT; end
      // Status data is not kept; the read exists for its clear side effect.
      S_RD_STAT: if (advance) state_d = S_PUSH;
      S_PUSH: begin
        rr_ptr_d         = sel_id_q + 5'd1;
        done_d           = done_q + 16'd1;
        mask_d[sel_id_q] = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    addr    = 32'h0;
    Wdata   = 32'h0;
    write   = 1'b0;
    read    = 1'b0;
    h_Rdata = 32'h0;
    if (!rst) begin
      if (host_own) begin
        addr  = h_addr;
        Wdata = h_Wdata;
        write = h_write && !ctrl_hit;
        read  = h_read  && !ctrl_hit;
        if (h_read) h_Rdata = ctrl_hit ? ctrl_val : Rdata;
      end else if (eng_rd) begin
        addr = rd_addr;
        read = 1'b1;
      end
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign res.res_valid = (count_q != '0);
  assign res.res_id    = res.res_valid ? head[100:96] : 5'd0;
  assign res.res_cnt   = res.res_valid ? head[95:64]  : 32'h0;
  assign res.res_corr  = res.res_valid ? head[63:0]   : 64'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 5'd0;
      mask_q   <= 32'h0;
      enable_q <= 1'b0;
      done_q   <= 16'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      mask_q   <= mask_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    sel_id_q <= sel_id_d;
    cnt_q    <= cnt_d;
    low_q    <= low_d;
    high_q   <= high_d;
    if (push) mem_q[wr_ptr_q] <= {sel_id_q, cnt_q, high_q, low_q};
  end

endmodule

// File: tb/tb_corr_readout_sched.sv
// Directed bench for corr_readout_sched with a behavioural correlator array
// and a result scoreboard drained by an independent monitor.
module tb_corr_readout_sched;
  localparam logic [31:0] BASE = 32'hFE00_0600;
  localparam logic [31:0] CTRL = 32'hFE00_0110;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] h_addr, h_Wdata, h_Rdata;
  logic        h_write, h_read;
  logic [31:0] addr, Wdata, Rdata;
  logic        write, read;
  logic [31:0] seen_m = 32'h0;
  logic [31:0] set_req, clr_mask, off;
  logic        hold_all, clr_all;

  int checks = 0;
  int errors = 0;
  logic [100:0] sb [$];

  corr_readout_sched_if rif();

  corr_readout_sched dut (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .h_Wdata(h_Wdata), .h_write(h_write), .h_read(h_read),
    .h_Rdata(h_Rdata),
    .addr(addr), .Wdata(Wdata), .write(write), .read(read), .Rdata(Rdata),
    .seen(seen_m), .res(rif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_of(input logic [4:0] k);
    return 32'hC000_0000 | {27'd0, k};
  endfunction
  function automatic logic [31:0] low_of(input logic [4:0] k);
    return 32'h1100_0000 | {27'd0, k};
  endfunction
  function automatic logic [31:0] high_of(input logic [4:0] k);
    return 32'h2200_0000 | {27'd0, k};
  endfunction
  function automatic logic [100:0] exp_of(input logic [4:0] k);
    return {k, cnt_of(k), high_of(k), low_of(k)};
  endfunction

  // Correlator array: combinational read data, Status read clears seen[k].
  always_comb begin
    off      = addr - BASE;
    Rdata    = 32'h0;
    clr_mask = 32'h0;
    if (read) begin
      if (off < 32'h200) begin
        case (off[3:0])
          4'h0:    Rdata = cnt_of(off[8:4]);
          4'h4:    Rdata = low_of(off[8:4]);
          4'h8:    Rdata = high_of(off[8:4]);
          default: begin Rdata = 32'h1; clr_mask[off[8:4]] = 1'b1; end
        endcase
      end else begin
        Rdata = 32'hD00D_0000 ^ addr;
      end
    end
  end

  always @(posedge clk) begin
    if (hold_all) seen_m <= 32'hFFFF_FFFF;
    else          seen_m <= ((seen_m & ~clr_mask) | set_req) & ~{32{clr_all}};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rif.res_valid && rif.res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result_id", {59'd0, rif.res_id}, 64'hFFFF);
      end else begin
        logic [100:0] e;
        e = sb.pop_front();
        check("res_id",   {59'd0, rif.res_id}, {59'd0, e[100:96]});
        check("res_cnt",  {32'd0, rif.res_cnt}, {32'd0, e[95:64]});
        check("res_corr", rif.res_corr, e[63:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic host_rd(input logic [31:0] a, output logic [31:0] d);
    h_read = 1'b1; h_addr = a;
    @(negedge clk); d = h_Rdata;
    step(); h_read = 1'b0; h_addr = 32'h0;
  endtask

  task automatic host_wr(input logic [31:0] a, input logic [31:0] d);
    h_write = 1'b1; h_addr = a; h_Wdata = d;
    step(); h_write = 1'b0; h_addr = 32'h0; h_Wdata = 32'h0;
  endtask

  task automatic set_seen(input logic [31:0] bits);
    set_req = bits; step(); set_req = 32'h0;
  endtask

  task automatic wait_eng_read(input logic [31:0] a, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (read && !h_read && !h_write && addr == a) ok = 1'b1;
    end
    check(name, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (sb.size() == 0 && !rif.res_valid) ok = 1'b1;
    end
    check(name, {63'd0, ok}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int n, busy;
    rst = 1'b1; h_addr = 32'h0; h_Wdata = 32'h0; h_write = 1'b0; h_read = 1'b0;
    set_req = 32'h0; hold_all = 1'b0; clr_all = 1'b0; rif.res_ready = 1'b1;

    // Reset: outputs forced low even with a host read pending.
    step(); step();
    h_read = 1'b1; h_addr = 32'hFE00_0104;
    @(negedge clk);
    check("rst_addr",    {32'd0, addr}, 64'd0);
    check("rst_read",    {63'd0, read}, 64'd0);
    check("rst_h_rdata", {32'd0, h_Rdata}, 64'd0);
    check("rst_valid",   {63'd0, rif.res_valid}, 64'd0);
    check("rst_res_id",  {59'd0, rif.res_id}, 64'd0);
    step(); h_read = 1'b0; h_addr = 32'h0; rst = 1'b0; step();
    host_rd(CTRL, d);
    check("ctrl_after_rst", {32'd0, d}, 64'd0);

    // CTRL writes touch only bit 0 and are never forwarded.
    h_write = 1'b1; h_addr = CTRL; h_Wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("ctrl_wr_not_fwd", {63'd0, write}, 64'd0);
    step(); h_write = 1'b0; h_addr = 32'h0; h_Wdata = 32'h0;
    host_rd(CTRL, d);
    check("ctrl_bit0_only", {32'd0, d}, 64'h1);

    // Single readout of id 30, uncontended latency.
    sb.push_back(exp_of(5'd30));
    set_seen(32'h4000_0000);
    for (int i = 0; i < 4; i++) begin
      step(); @(negedge clk);
      check("t1_bus_read", {31'd0, read, addr}, {31'd0, 1'b1, 32'hFE00_07E0 + 32'(4 * i)});
    end
    step(); @(negedge clk);
    check("t1_push_cycle_valid", {63'd0, rif.res_valid}, 64'd0);
    step(); @(negedge clk);
    check("t1_valid_cycle6", {63'd0, rif.res_valid}, 64'd1);
    wait_drain(10, "t1_drain");

    // Round robin over all 32 with seen held high: 0..31, 0.
    do_reset();
    for (int k = 0; k < 33; k++) sb.push_back(exp_of(5'(k)));
    hold_all = 1'b1;
    host_wr(CTRL, 32'h1);
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      if (read && !h_read && addr[3:0] == 4'h0) n++;
    end
    step();
    host_rd(CTRL, d);
    check("rr_count_mid", {48'd0, d[31:16]}, 64'd9);
    for (int i = 0; i < 400 && n < 33; i++) begin
      @(negedge clk);
      if (read && !h_read && addr[3:0] == 4'h0) n++;
    end
    check("rr_cnt_reads", n, 33);
    step();
    host_wr(CTRL, 32'h0);
    wait_drain(40, "rr_drain");
    host_rd(CTRL, d);
    check("rr_count_end", {48'd0, d[31:16]}, 64'd33);
    check("rr_enable_off", {63'd0, d[0]}, 64'd0);
    hold_all = 1'b0; clr_all = 1'b1; step(); clr_all = 1'b0;

    // FIFO full back-pressure: four queue, fifth waits for a pop.
    rif.res_ready = 1'b0;
    sb.push_back(exp_of(5'd3)); sb.push_back(exp_of(5'd5)); sb.push_back(exp_of(5'd7));
    sb.push_back(exp_of(5'd9)); sb.push_back(exp_of(5'd11));
    host_wr(CTRL, 32'h1);
    set_seen(32'h0000_0AA8);
    for (int i = 0; i < 40; i++) step();
    host_rd(CTRL, d);
    check("full_occupancy", {56'd0, d[15:8]}, 64'd4);
    busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); if (read) busy++;
      step();
    end
    check("full_no_reads", busy, 0);
    rif.res_ready = 1'b1; step(); rif.res_ready = 1'b0;
    wait_eng_read(BASE + 32'h0B0, 20, "full_fifth_starts");
    step(); rif.res_ready = 1'b1;
    wait_drain(60, "full_drain");

    // Host read during RD_LOW of id 2.
    sb.push_back(exp_of(5'd2));
    set_seen(32'h0000_0004);
    step();
    step(); h_read = 1'b1; h_addr = 32'hFE00_0104;
    @(negedge clk);
    check("host_fwd", {31'd0, read, addr}, {31'd0, 1'b1, 32'hFE00_0104});
    check("host_rdata", {32'd0, h_Rdata}, 64'h2E0D_0104);
    step(); h_read = 1'b0; h_addr = 32'h0;
    @(negedge clk);
    check("low_held", {31'd0, read, addr}, {31'd0, 1'b1, 32'hFE00_0624});
    step(); @(negedge clk);
    check("high_after", {31'd0, read, addr}, {31'd0, 1'b1, 32'hFE00_0628});
    wait_drain(20, "host_drain");

    // Disable during RD_HIGH of id 6.
    sb.push_back(exp_of(5'd6));
    set_seen(32'h0000_0040);
    step(); step(); step();
    h_write = 1'b1; h_addr = CTRL; h_Wdata = 32'h0;
    @(negedge clk);
    check("dis_not_fwd", {62'd0, write, read}, 64'd0);
    step(); h_write = 1'b0; h_addr = 32'h0;
    wait_drain(20, "dis_drain");
    set_seen(32'h0000_0100);
    busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); if (read) busy++;
      step();
    end
    check("dis_no_select", busy, 0);
    host_rd(CTRL, d);
    check("dis_bit0", {63'd0, d[0]}, 64'd0);

    // Reset during RD_HIGH of id 10 with id 8 queued.
    rif.res_ready = 1'b0;
    sb.push_back(exp_of(5'd8));
    set_seen(32'h0000_0500);
    host_wr(CTRL, 32'h1);
    wait_eng_read(BASE + 32'h0A0, 40, "rst_reach_id10");
    step(); step(); rst = 1'b1;
    @(negedge clk);
    check("rst_mid_bus", {31'd0, read, addr}, 64'd0);
    step(); rst = 1'b0; sb.delete();
    @(negedge clk);
    check("rst_mid_valid", {63'd0, rif.res_valid}, 64'd0);
    step();
    host_rd(CTRL, d);
    check("rst_mid_ctrl", {32'd0, d}, 64'd0);
    rif.res_ready = 1'b1;
    sb.push_back(exp_of(5'd10));
    host_wr(CTRL, 32'h1);
    busy = 0;
    for (int i = 0; i < 10 && busy == 0; i++) begin
      @(negedge clk);
      if (read) begin
        busy = 1;
        check("reread_from_cnt", {32'd0, addr}, {32'd0, BASE + 32'h0A0});
      end
    end
    check("reread_seen", busy, 1);
    step();
    wait_drain(20, "reread_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
